// File: rtl/round_sgf_apply.sv
// round_sgf_apply
//   Sequential directed-rounding stage for the add/subtract datapath. Takes a
//   normalized significand with two extra rounding bits, decides whether to
//   increment, applies the increment, renormalizes on carry-out, and presents
//   the final significand/exponent pair with a one-cycle Ready_o pulse.
//   Fixed latency: Start_i sampled at edge 0, results and Ready_o at edge 4.
//
// Ports
//   clk           : clock, rising edge
//   rst           : synchronous active-high reset
//   Start_i       : single-cycle request, honoured only when idle
//   Sgf_i         : [SW+1:2] kept bits, [1:0] rounding bits
//   Exp_i         : biased exponent
//   Sign_Result_i : result sign (1 = negative)
//   Round_type_i  : 00 toward zero, 01 toward -inf, 10 toward +inf, 11 as 00
//   Sgf_o         : rounded significand
//   Exp_o         : rounded exponent
//   Round_Flag_o  : increment applied
//   Overflow_o    : rounding carried the exponent to all-ones
//   Ready_o       : one-cycle pulse, outputs valid from this cycle
//   Busy_o        : high whenever not idle
module round_sgf_apply #(
  parameter int SW = 24,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Start_i,
  input  logic [SW+1:0] Sgf_i,
  input  logic [EW-1:0] Exp_i,
  input  logic          Sign_Result_i,
  input  logic [1:0]    Round_type_i,
  output logic [SW-1:0] Sgf_o,
  output logic [EW-1:0] Exp_o,
  output logic          Round_Flag_o,
  output logic          Overflow_o,
  output logic          Ready_o,
  output logic          Busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECIDE,
    S_INCR,
    S_NORM,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  // Captured request
  logic [SW+1:0] r_sgf_in;
  logic [EW-1:0] r_exp_in;
  logic          r_sign;
  logic [1:0]    r_mode;

  // Pipeline of intermediate results, one per state
  logic          r_rf;
  logic [SW:0]   r_sum;
  logic [SW-1:0] r_sgf_n;
  logic [EW-1:0] r_exp_n;
  logic          r_ovf_n;

  // Output registers
  logic [SW-1:0] r_sgf_o;
  logic [EW-1:0] r_exp_o;
  logic          r_rf_o;
  logic          r_ovf_o;
  logic          r_ready;

  logic          w_rbits_nz;
  logic          w_rf;
  logic [EW-1:0] w_exp_inc;
  logic          w_busy;

  assign w_rbits_nz = |r_sgf_in[1:0];
  // Only the two directed modes that round away from zero for this sign increment.
  assign w_rf = w_rbits_nz &
                (((r_mode == 2'b01) &  r_sign) |
                 ((r_mode == 2'b10) & ~r_sign));
  assign w_exp_inc = r_exp_in + EW'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (Start_i) w_next = S_DECIDE;
      S_DECIDE: w_next = S_INCR;
      S_INCR:   w_next = S_NORM;
      S_NORM:   w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_busy = (r_state != S_IDLE);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sgf_in <= '0;
      r_exp_in <= '0;
      r_sign   <= 1'b0;
      r_mode   <= '0;
      r_rf     <= 1'b0;
      r_sum    <= '0;
      r_sgf_n  <= '0;
      r_exp_n  <= '0;
      r_ovf_n  <= 1'b0;
      r_sgf_o  <= '0;
      r_exp_o  <= '0;
      r_rf_o   <= 1'b0;
      r_ovf_o  <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (Start_i) begin
            r_sgf_in <= Sgf_i;
            r_exp_in <= Exp_i;
            r_sign   <= Sign_Result_i;
            r_mode   <= Round_type_i;
          end
        end
        S_DECIDE: r_rf <= w_rf;
        S_INCR:   r_sum <= {1'b0, r_sgf_in[SW+1:2]} + {{SW{1'b0}}, r_rf};
        S_NORM: begin
          r_ovf_n <= 1'b0;
          if (r_sum[SW]) begin
            r_sgf_n <= r_sum[SW:1];
            if (&r_exp_in) begin
              // Saturated exponent is left alone; the carry is not propagated.
              r_exp_n <= r_exp_in;
            end else begin
              r_exp_n <= w_exp_inc;
              if (&w_exp_inc) begin
                r_ovf_n <= 1'b1;
                r_sgf_n <= '0;
              end
            end
          end else begin
            r_sgf_n <= r_sum[SW-1:0];
            r_exp_n <= r_exp_in;
          end
        end
        S_DONE: begin
          r_sgf_o <= r_sgf_n;
          r_exp_o <= r_exp_n;
          r_rf_o  <= r_rf;
          r_ovf_o <= r_ovf_n;
          r_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Sgf_o        = r_sgf_o;
  assign Exp_o        = r_exp_o;
  assign Round_Flag_o = r_rf_o;
  assign Overflow_o   = r_ovf_o;
  assign Ready_o      = r_ready;
  assign Busy_o       = w_busy;

endmodule

// File: tb/tb_round_sgf_apply.sv
module tb_round_sgf_apply;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start_i;
  logic [25:0] Sgf_i;
  logic [7:0]  Exp_i;
  logic        Sign_Result_i;
  logic [1:0]  Round_type_i;
  logic [23:0] Sgf_o;
  logic [7:0]  Exp_o;
  logic        Round_Flag_o;
  logic        Overflow_o;
  logic        Ready_o;
  logic        Busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  round_sgf_apply #(.SW(24), .EW(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .Start_i       (Start_i),
    .Sgf_i         (Sgf_i),
    .Exp_i         (Exp_i),
    .Sign_Result_i (Sign_Result_i),
    .Round_type_i  (Round_type_i),
    .Sgf_o         (Sgf_o),
    .Exp_o         (Exp_o),
    .Round_Flag_o  (Round_Flag_o),
    .Overflow_o    (Overflow_o),
    .Ready_o       (Ready_o),
    .Busy_o        (Busy_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: rounding decided from the rules with plain integer arithmetic.
  task automatic model(input logic [25:0] s, input logic [7:0] e, input logic sg,
                       input logic [1:0] m, output logic [23:0] xs, output logic [7:0] xe,
                       output logic xr, output logic xo);
    longint kept, rb, sum;
    int     ei;
    kept = longint'(s) / 4;
    rb   = longint'(s) % 4;
    xr   = (rb != 0) && ((m == 2'd1 && sg) || (m == 2'd2 && !sg));
    sum  = kept + (xr ? 1 : 0);
    ei   = int'(e);
    xo   = 1'b0;
    if (sum == 64'd16777216) begin
      if (ei == 255) begin
        xe = 8'd255; xs = 24'h800000;
      end else if (ei + 1 == 255) begin
        xe = 8'd255; xs = 24'h0; xo = 1'b1;
      end else begin
        xe = 8'(ei + 1); xs = 24'h800000;
      end
    end else begin
      xs = 24'(sum);
      xe = e;
    end
  endtask

  // One operation; junk=1 adds ignored Start_i pulses at edges 1 and 3.
  // Inputs are scrambled while busy to show the captured request is used.
  task automatic do_op(input string tag, input logic [25:0] s, input logic [7:0] e,
                       input logic sg, input logic [1:0] m, input bit junk);
    logic [23:0] xs; logic [7:0] xe; logic xr, xo;
    int lat, nready;
    model(s, e, sg, m, xs, xe, xr, xo);
    @(negedge clk);
    Start_i = 1'b1; Sgf_i = s; Exp_i = e; Sign_Result_i = sg; Round_type_i = m;
    @(posedge clk); #1;
    Start_i = 1'b0;
    check_val({tag, ":busy0"}, 32'(Busy_o), 32'd1);
    lat = 0; nready = 0;
    for (int k = 1; k <= 7; k++) begin
      Sgf_i = 26'($urandom); Exp_i = 8'($urandom);
      Sign_Result_i = 1'($urandom); Round_type_i = 2'($urandom);
      if (junk && (k == 1 || k == 3)) Start_i = 1'b1;
      @(posedge clk); #1;
      Start_i = 1'b0;
      if (Ready_o) begin
        nready++;
        if (lat == 0) lat = k;
      end
      if (k < 4) check_val({tag, ":busy"}, 32'(Busy_o), 32'd1);
      if (k == 4) check_val({tag, ":idle"}, 32'(Busy_o), 32'd0);
    end
    check_val({tag, ":lat"}, 32'(lat), 32'd4);
    check_val({tag, ":nrdy"}, 32'(nready), 32'd1);
    check_val({tag, ":sgf"}, 32'(Sgf_o), 32'(xs));
    check_val({tag, ":exp"}, 32'(Exp_o), 32'(xe));
    check_val({tag, ":rf"}, 32'(Round_Flag_o), 32'(xr));
    check_val({tag, ":ovf"}, 32'(Overflow_o), 32'(xo));
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, ":sgf"}, 32'(Sgf_o), 32'd0);
    check_val({tag, ":exp"}, 32'(Exp_o), 32'd0);
    check_val({tag, ":rf"}, 32'(Round_Flag_o), 32'd0);
    check_val({tag, ":ovf"}, 32'(Overflow_o), 32'd0);
    check_val({tag, ":rdy"}, 32'(Ready_o), 32'd0);
    check_val({tag, ":busy"}, 32'(Busy_o), 32'd0);
  endtask

  initial begin
    int nready;
    logic [25:0] s;
    logic [7:0]  e;
    rst = 1'b1; Start_i = 1'b0; Sgf_i = '0; Exp_i = '0;
    Sign_Result_i = 1'b0; Round_type_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk); rst = 1'b0;

    // Directed cases
    do_op("trunc",  26'h3FFFFFF, 8'h80, 1'b0, 2'b00, 0);
    do_op("pinf_p", 26'h2000001, 8'h40, 1'b0, 2'b10, 0);
    do_op("pinf_n", 26'h2000001, 8'h40, 1'b1, 2'b10, 0);
    do_op("carry",  26'h3FFFFFE, 8'h7F, 1'b0, 2'b10, 0);
    do_op("ovf",    26'h3FFFFFF, 8'hFE, 1'b1, 2'b01, 0);
    do_op("expff",  26'h3FFFFFF, 8'hFF, 1'b1, 2'b01, 0);

    // Mode sweep: {sign, mode, rbits} with kept = 1
    for (int i = 0; i < 32; i++) begin
      s = {24'h000001, 2'(i)};
      do_op("sweep", s, 8'h55, 1'(i >> 4), 2'(i >> 2), 0);
    end

    // Ignored starts while busy
    do_op("junk", 26'h2000003, 8'h10, 1'b1, 2'b01, 1);

    // Reset at edge 2 of an operation
    @(negedge clk);
    Start_i = 1'b1; Sgf_i = 26'h3FFFFFE; Exp_i = 8'h22;
    Sign_Result_i = 1'b0; Round_type_i = 2'b10;
    @(posedge clk); #1; Start_i = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check_zero("abort");
    nready = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (Ready_o) nready++;
    end
    check_val("abort:nrdy", 32'(nready), 32'd0);
    do_op("after_abort", 26'h0000005, 8'h33, 1'b0, 2'b10, 0);

    // Reset and start together: request dropped
    @(negedge clk);
    rst = 1'b1; Start_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; Start_i = 1'b0;
    check_val("rst_start:busy", 32'(Busy_o), 32'd0);
    nready = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (Ready_o) nready++;
    end
    check_val("rst_start:nrdy", 32'(nready), 32'd0);

    // Random, biased toward carry and exponent boundaries
    for (int n = 0; n < 60; n++) begin
      s = 26'($urandom);
      e = 8'($urandom);
      if ($urandom_range(0, 3) == 0) s = {24'hFFFFFF, 2'($urandom)};
      if ($urandom_range(0, 3) == 0) e = 8'($urandom_range(253, 255));
      do_op("rand", s, e, 1'($urandom), 2'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
